// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if -- request/result bundle for the sequential divider.
//
// The master drives the request side:
//   start, signed_op, dividend[DW-1:0], divisor[VW-1:0]
// The slave (the divider) drives the result side:
//   busy, done, q[DW-1:0], r[VW-1:0], dz, ovf
// ---------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  // Request side
  logic          start;
  logic          signed_op;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;

  // Result side
  logic          busy;
  logic          done;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          dz;
  logic          ovf;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, q, r, dz, ovf
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, q, r, dz, ovf
  );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider -- multi-cycle restoring divider, signed or unsigned.
//
// Ports:
//   clk  : single clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : seq_divider_if.slave
//          start/signed_op/dividend/divisor are sampled in IDLE only;
//          busy is high in RUN, done pulses for one cycle in DONE, and
//          q/r/dz/ovf are registered and held until the next done.
//
// Operation: operands are converted to magnitudes on the accepting edge,
// divided one quotient bit per cycle (MSB first) for DW cycles, and the
// signs are re-applied as the result is registered. Signed division
// truncates toward zero; the remainder takes the dividend's sign.
// Divide-by-zero skips RUN and reports q = all ones, r = 0, dz = 1.
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // FSM and iteration counter
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Datapath: quo_q starts as the dividend magnitude and is shifted left
  // each cycle, its vacated LSB receiving the new quotient bit. rem_q is
  // one bit wider than the divisor so the shifted-in trial value is exact.
  logic [DW-1:0] quo_q,   quo_d;
  logic [VW:0]   rem_q,   rem_d;
  logic [VW-1:0] dvs_q,   dvs_d;
  logic          negq_q,  negq_d;
  logic          negr_q,  negr_d;
  logic          ovfp_q,  ovfp_d;

  // Registered results
  logic [DW-1:0] q_q,     q_d;
  logic [VW-1:0] r_q,     r_d;
  logic          dz_q,    dz_d;
  logic          ovf_q,   ovf_d;

  // Operand conditioning on the request side
  logic          dvd_neg, dvs_neg;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic          is_ovf_case;

  // One restoring step
  logic [VW:0]   trial;
  logic          fits;
  logic [VW:0]   rem_next;
  logic [DW-1:0] quo_next;
  logic [DW-1:0] q_final;
  logic [VW-1:0] r_final;

  // Magnitudes are taken as plain unsigned values of the operand width,
  // so negating the most-negative value yields 2^(W-1) without overflow.
  assign dvd_neg     = bus.signed_op & bus.dividend[DW-1];
  assign dvs_neg     = bus.signed_op & bus.divisor[VW-1];
  assign dvd_mag     = dvd_neg ? (DW'(0) - bus.dividend) : bus.dividend;
  assign dvs_mag     = dvs_neg ? (VW'(0) - bus.divisor)  : bus.divisor;
  assign is_ovf_case = bus.signed_op && (bus.dividend == MOST_NEG) &&
                       (bus.divisor == {VW{1'b1}});

  // rem_q < dvs_q always holds after a step, so its top bit is zero and
  // the shifted value fits in VW+1 bits.
  assign trial    = {rem_q[VW-1:0], quo_q[DW-1]};
  assign fits     = (trial >= {1'b0, dvs_q});
  assign rem_next = fits ? (trial - {1'b0, dvs_q}) : trial;
  assign quo_next = {quo_q[DW-2:0], fits};

  // Sign restoration applied to the final step's values.
  assign q_final  = negq_q ? (DW'(0) - quo_next) : quo_next;
  assign r_final  = negr_q ? (VW'(0) - rem_next[VW-1:0]) : rem_next[VW-1:0];

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    ovfp_d  = ovfp_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          quo_d  = dvd_mag;
          rem_d  = '0;
          dvs_d  = dvs_mag;
          cnt_d  = '0;
          negq_d = dvd_neg ^ dvs_neg;
          negr_d = dvd_neg;
          ovfp_d = is_ovf_case;
          if (bus.divisor == '0) begin
            // Results are published now; this edge enters the done cycle.
            state_d = S_DONE;
            q_d     = '1;
            r_d     = '0;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        quo_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_DONE;
          q_d     = q_final;
          r_d     = r_final;
          dz_d    = 1'b0;
          ovf_d   = ovfp_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      ovfp_q  <= ovfp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dz   = dz_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DW, default 8, dividend and quotient width in bits (DW >= 2).
REQ-002 Parameter VW, default 4, divisor and remainder width in bits (2 <= VW <= DW).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 signed_op  input  1  1 = operands two's-complement signed, 0 = unsigned; sampled with start.
REQ-007 dividend  input  DW  dividend operand; sampled with start.
REQ-008 divisor  input  VW  divisor operand; sampled with start.
REQ-009 busy  output  1  high while a division is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse; q, r, dz and ovf are valid in that cycle.
REQ-011 q  output  DW  quotient.
REQ-012 r  output  VW  remainder.
REQ-013 dz  output  1  divide-by-zero flag.
REQ-014 ovf  output  1  signed overflow flag (most-negative / -1).

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 Transitions SHALL be:
- IDLE -> RUN on start with divisor != 0.
- IDLE -> DONE on start with divisor == 0.
- RUN -> DONE after exactly DW RUN cycles.
- DONE -> IDLE unconditionally.
REQ-017 On an accepted start, operands and signed_op SHALL be captured into internal registers; later input changes SHALL NOT affect the operation.
REQ-018 start SHALL be ignored while busy or done is high; no queuing.
REQ-019 Division SHALL use a shift-subtract (restoring) algorithm on operand magnitudes, producing one quotient bit per RUN cycle, MSB first.
REQ-020 The partial remainder register SHALL be VW+1 bits wide so that a trial subtract never loses a carry.
REQ-021 Latency: done SHALL assert exactly DW+1 cycles after the start-accept edge for a nonzero divisor, and 1 cycle after it for a zero divisor.
REQ-022 Unsigned mode SHALL give q = floor(dividend/divisor) and r = dividend mod divisor.
REQ-023 Signed mode SHALL truncate toward zero:
- quotient negative iff operand signs differ;
- remainder carries the dividend's sign;
- abs(r) < abs(divisor).
REQ-024 Signed mode SHALL take magnitudes as unsigned DW- and VW-bit values, so a most-negative operand converts correctly.
REQ-025 Divisor == 0: q SHALL be all ones, r SHALL be 0, dz SHALL be 1 and ovf SHALL be 0, in either mode.
REQ-026 Signed, dividend = -2^(DW-1) and divisor = -1: q SHALL be the wrapped value 2^(DW-1), r SHALL be 0 and ovf SHALL be 1.
REQ-027 q, r, dz and ovf SHALL be registered and SHALL hold from the done cycle until the next accepted start's done cycle.
REQ-028 busy SHALL be 1 exactly during the RUN state.
REQ-029 done SHALL be 1 exactly during the DONE state.

Reset
REQ-030 While rst is high at a clock edge, the FSM SHALL return to IDLE and busy, done, q, r, dz and ovf SHALL all be 0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-032 Reset SHALL take priority over start in the same cycle.
REQ-033 A start applied in the first cycle after rst deasserts SHALL be accepted.

Verification (DW=8, VW=4)
REQ-034 Unsigned 13/2 -> q=8'd6, r=4'd1, dz=0, done exactly 9 cycles after start accept.
REQ-035 Back-to-back unsigned operations: 15/4 -> q=3, r=3; then 255/15 -> q=17, r=0; start asserted in the DONE cycle is ignored.
REQ-036 Divide by zero: 200/0 -> q=8'hFF, r=0, dz=1, done 1 cycle after accept.
REQ-037 Signed operations:
- -7/2 -> q=8'hFD (-3), r=4'hF (-1);
- 7/-2 -> q=8'hFD, r=4'h1;
- -128/-1 -> q=8'h80, r=0, ovf=1.
REQ-038 Operand changes and start pulses during RUN leave the result unchanged (13/2 still gives 6 r 1).
REQ-039 rst asserted at RUN cycle 4 -> busy=0, done never pulses, outputs 0; a following start of 9/3 gives q=3, r=0.
